// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the register-file write arbiter.
//   ADDR_W / DATA_W / NUM_REGS : register-file geometry
//   LAST_ADDR                  : highest register index, used to end a clear sweep
//   state_e                    : arbiter controller states
//   grant_e                    : which requester won the most recent handshake
package regfile_pkg;

    localparam int ADDR_W   = 3;
    localparam int DATA_W   = 8;
    localparam int NUM_REGS = 8;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        IDLE  = 2'd1,
        CLEAR = 2'd2
    } state_e;

    typedef enum logic {
        GNT_A = 1'b0,
        GNT_B = 1'b1
    } grant_e;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin selector, purely combinational.
//   req[0]     : requester A pending
//   req[1]     : requester B pending
//   last_grant : requester that won the previous handshake
//   gnt[1:0]   : one-hot grant (bit0 = A, bit1 = B), zero when nothing pending
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic [1:0] req,
    input  grant_e     last_grant,
    output logic [1:0] gnt
);

    // Lone requester wins outright; on a tie the one not served last wins.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_grant == GNT_B) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: merges two write requesters (A = core writeback,
// B = debug port) onto a single registered register-file write port, and
// runs a zero-fill sweep of every register on request or after reset.
//   clk, rst_n            : clock, asynchronous active-low reset
//   clr_req / clr_busy    : request a zero-fill sweep / sweep pending or running
//   a_valid/a_ready/a_addr/a_data : requester A handshake and payload
//   b_valid/b_ready/b_addr/b_data : requester B handshake and payload
//   rf_we / rf_rd / rf_wd : registered register-file write enable/address/data
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              clr_busy,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_wd
);

    localparam state_e RST_STATE = CLEAR_ON_RESET ? INIT : IDLE;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    grant_e            last_grant_q, last_grant_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_rd_q, rf_rd_d;
    logic [DATA_W-1:0] rf_wd_q, rf_wd_d;

    logic [1:0]        gnt_s;
    logic              accept_s;
    logic              a_hs_s;
    logic              b_hs_s;

    rr_arbiter2 u_rr_arbiter2 (
        .req        ({b_valid, a_valid}),
        .last_grant (last_grant_q),
        .gnt        (gnt_s)
    );

    // A pending clear takes priority, so no requester is acknowledged that cycle.
    assign accept_s = (state_q == IDLE) && !clr_req;
    assign a_ready  = accept_s && gnt_s[0];
    assign b_ready  = accept_s && gnt_s[1];
    assign a_hs_s   = a_valid && a_ready;
    assign b_hs_s   = b_valid && b_ready;

    assign clr_busy = (state_q != IDLE);
    assign rf_we    = rf_we_q;
    assign rf_rd    = rf_rd_q;
    assign rf_wd    = rf_wd_q;

    // Next-state, sweep counter and write-port staging.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        rf_we_d      = 1'b0;
        rf_rd_d      = rf_rd_q;
        rf_wd_d      = rf_wd_q;
        case (state_q)
            INIT: begin
                state_d = CLEAR;
                cnt_d   = {ADDR_W{1'b0}};
                rf_we_d = 1'b1;
                rf_rd_d = {ADDR_W{1'b0}};
                rf_wd_d = {DATA_W{1'b0}};
            end
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = {ADDR_W{1'b0}};
                    rf_we_d = 1'b1;
                    rf_rd_d = {ADDR_W{1'b0}};
                    rf_wd_d = {DATA_W{1'b0}};
                end else if (a_hs_s) begin
                    last_grant_d = GNT_A;
                    rf_we_d      = 1'b1;
                    rf_rd_d      = a_addr;
                    rf_wd_d      = a_data;
                end else if (b_hs_s) begin
                    last_grant_d = GNT_B;
                    rf_we_d      = 1'b1;
                    rf_rd_d      = b_addr;
                    rf_wd_d      = b_data;
                end else begin
                    rf_we_d = 1'b0;
                end
            end
            CLEAR: begin
                // cnt_q tracks the register currently on the write port.
                if (cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                    rf_we_d = 1'b0;
                end else begin
                    cnt_d   = cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    rf_we_d = 1'b1;
                    rf_rd_d = cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    rf_wd_d = {DATA_W{1'b0}};
                end
            end
            default: begin
                state_d = IDLE;
                rf_we_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any sweep or staged write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RST_STATE;
            cnt_q        <= {ADDR_W{1'b0}};
            last_grant_q <= GNT_B;
            rf_we_q      <= 1'b0;
            rf_rd_q      <= {ADDR_W{1'b0}};
            rf_wd_q      <= {DATA_W{1'b0}};
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            rf_we_q      <= rf_we_d;
            rf_rd_q      <= rf_rd_d;
            rf_wd_q      <= rf_wd_d;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed scenarios plus randomized traffic,
// checked cycle by cycle against a transaction-level reference model.
module tb_regfile_write_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr_req;
    logic       clr_busy;
    logic       a_valid, a_ready, b_valid, b_ready;
    logic [2:0] a_addr, b_addr;
    logic [7:0] a_data, b_data;
    logic       rf_we;
    logic [2:0] rf_rd;
    logic [7:0] rf_wd;

    int checks = 0;
    int errors = 0;

    // Reference model: pending start-up sweep, remaining sweep cycles,
    // who won last, and the expected write-port contents.
    bit         m_init;
    int         m_sweep;
    bit         m_last_a;
    logic       m_we;
    logic [2:0] m_rd;
    logic [7:0] m_wd;
    bit         a_acc, b_acc;

    regfile_write_arbiter #(.CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .clr_busy(clr_busy),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_port();
        check_eq("rf_we", 32'(rf_we), 32'(m_we));
        check_eq("rf_rd", 32'(rf_rd), 32'(m_rd));
        check_eq("rf_wd", 32'(rf_wd), 32'(m_wd));
        check_eq("clr_busy", 32'(clr_busy), 32'(m_init || (m_sweep > 0)));
    endtask

    // One clock: check readies against model, advance model at the edge, check outputs.
    task automatic cycle();
        bit idle, acc, ea, eb;
        #1;
        idle = !m_init && (m_sweep == 0);
        acc  = idle && !clr_req;
        ea   = acc && a_valid && (!b_valid || !m_last_a);
        eb   = acc && b_valid && (!a_valid || m_last_a);
        check_eq("a_ready", 32'(a_ready), 32'(ea));
        check_eq("b_ready", 32'(b_ready), 32'(eb));
        @(posedge clk);
        if (m_init) begin
            m_init = 1'b0; m_sweep = 8; m_we = 1'b1; m_rd = 3'd0; m_wd = 8'd0;
        end else if (m_sweep > 0) begin
            m_sweep--;
            if (m_sweep == 0) m_we = 1'b0;
            else begin m_we = 1'b1; m_rd = m_rd + 3'd1; end
        end else if (clr_req) begin
            m_sweep = 8; m_we = 1'b1; m_rd = 3'd0; m_wd = 8'd0;
        end else if (ea) begin
            m_we = 1'b1; m_rd = a_addr; m_wd = a_data; m_last_a = 1'b1;
        end else if (eb) begin
            m_we = 1'b1; m_rd = b_addr; m_wd = b_data; m_last_a = 1'b0;
        end else begin
            m_we = 1'b0;
        end
        a_acc = ea;
        b_acc = eb;
        #1;
        check_port();
    endtask

    // Asynchronous reset: outputs must clear immediately, mid-cycle.
    task automatic apply_reset();
        rst_n = 1'b0; clr_req = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        m_init = 1'b1; m_sweep = 0; m_last_a = 1'b0;
        m_we = 1'b0; m_rd = 3'd0; m_wd = 8'd0; a_acc = 1'b0; b_acc = 1'b0;
        #1;
        check_port();
        repeat (2) @(posedge clk);
        #1;
        check_port();
        rst_n = 1'b1;
    endtask

    // Random traffic that keeps an unaccepted request stable.
    task automatic rand_inputs();
        if (!(a_valid && !a_acc)) begin
            a_valid = 1'($urandom_range(0, 1)); a_addr = 3'($urandom); a_data = 8'($urandom);
        end
        if (!(b_valid && !b_acc)) begin
            b_valid = 1'($urandom_range(0, 1)); b_addr = 3'($urandom); b_data = 8'($urandom);
        end
        clr_req = ($urandom_range(0, 15) == 0);
    endtask

    initial begin
        int busy_cnt, we_cnt, n, grants;
        rst_n = 1'b1; clr_req = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        a_addr = 3'd0; b_addr = 3'd0; a_data = 8'd0; b_data = 8'd0;
        #2;

        // Start-up sweep: busy 9 cycles, 8 zero writes.
        apply_reset();
        busy_cnt = int'(clr_busy); we_cnt = int'(rf_we);
        for (int i = 0; i < 11; i++) begin
            cycle();
            busy_cnt += int'(clr_busy);
            we_cnt   += int'(rf_we);
        end
        check_eq("startup_busy_cycles", 32'(busy_cnt), 32'd9);
        check_eq("startup_we_cycles", 32'(we_cnt), 32'd8);

        // Single A write.
        a_valid = 1'b1; a_addr = 3'd3; a_data = 8'h5A;
        cycle();
        check_eq("single_a_rd", 32'(rf_rd), 32'd3);
        check_eq("single_a_wd", 32'(rf_wd), 32'h5A);
        a_valid = 1'b0;
        cycle();

        // Tie after reset: A, B, A, B with no bubble.
        apply_reset();
        repeat (9) cycle();
        a_valid = 1'b1; b_valid = 1'b1; a_addr = 3'd1; b_addr = 3'd2;
        a_data = 8'h11; b_data = 8'h22;
        grants = 0; we_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            grants = (grants << 2) | (int'(b_acc) << 1) | int'(a_acc);
            we_cnt += int'(rf_we);
        end
        check_eq("tie_grant_order", 32'(grants), 32'b01_10_01_10);
        check_eq("tie_we_cycles", 32'(we_cnt), 32'd4);
        a_valid = 1'b0; b_valid = 1'b0;
        cycle();

        // Clear beats a simultaneous A request; A served right after the sweep.
        clr_req = 1'b1; a_valid = 1'b1; a_addr = 3'd5; a_data = 8'h33;
        cycle();
        clr_req = 1'b0;
        n = 0;
        while (!a_acc && n < 20) begin cycle(); n++; end
        check_eq("clr_then_a_wait", 32'(n), 32'd9);
        a_valid = 1'b0;
        cycle();

        // clr_req pulses during a sweep are ignored.
        clr_req = 1'b1;
        cycle();
        busy_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            clr_req = (i == 2 || i == 6 || i == 7);
            cycle();
            busy_cnt += int'(clr_busy);
        end
        clr_req = 1'b0;
        check_eq("clr_ignored_busy", 32'(busy_cnt), 32'd7);

        // Reset mid-sweep at rf_rd=4, then the sweep restarts from 0.
        apply_reset();
        repeat (5) cycle();
        check_eq("mid_clear_rd", 32'(rf_rd), 32'd4);
        apply_reset();
        repeat (10) cycle();

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            rand_inputs();
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
